bfp_to_fp_converter: RTL and testbench

BFP_TO_FP_CONVERTER -- requirements
Module: bfp_to_fp_converter

---
 rtl/bfp_to_fp_converter_if.sv | 30 +++
 rtl/bfp_to_fp_converter.sv | 119 +++++++++++
 tb/tb_bfp_to_fp_converter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bfp_to_fp_converter_if.sv
// Handshake bus between a block-floating-point producer, the converter and a
// floating-point consumer. The converter sits on the slave modport.
interface bfp_to_fp_converter_if #(
    parameter int SYST_ARRAY_WIDTH         = 32,
    parameter int QUNATIZED_MANTISSA_WIDTH = 7,
    parameter int EXPONENT_WIDTH           = 8
);
    localparam int W = SYST_ARRAY_WIDTH;
    localparam int M = QUNATIZED_MANTISSA_WIDTH;
    localparam int E = EXPONENT_WIDTH;

    logic                 bfp_valid_i;
    logic                 bfp_ready_o;
    logic [E-1:0]         bfp_exponent_i;
    logic [W*M-1:0]       bfp_mantissa_i;
    logic                 fp_valid_o;
    logic                 fp_ready_i;
    logic [W*(E+M)-1:0]   fp_data_o;
    logic                 fp_underflow_o;

    modport master (
        output bfp_valid_i, bfp_exponent_i, bfp_mantissa_i, fp_ready_i,
        input  bfp_ready_o, fp_valid_o, fp_data_o, fp_underflow_o
    );

    modport slave (
        input  bfp_valid_i, bfp_exponent_i, bfp_mantissa_i, fp_ready_i,
        output bfp_ready_o, fp_valid_o, fp_data_o, fp_underflow_o
    );
endinterface

// File: rtl/bfp_to_fp_converter.sv
// Three-stage converter from a shared-exponent block to per-lane normalized
// {exponent, sign-magnitude} values; lanes that would need a negative exponent flush to zero.
module bfp_to_fp_converter #(
    parameter int SYST_ARRAY_WIDTH         = 32,
    parameter int QUNATIZED_MANTISSA_WIDTH = 7,
    parameter int EXPONENT_WIDTH           = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bfp_to_fp_converter_if.slave  bus
);
    localparam int W  = SYST_ARRAY_WIDTH;
    localparam int M  = QUNATIZED_MANTISSA_WIDTH;
    localparam int E  = EXPONENT_WIDTH;
    localparam int LW = $clog2(M);  // wide enough for M-1, the zero-magnitude code

    // The whole pipeline moves in lockstep; only a stalled output blocks it.
    logic adv;
    assign adv             = ~bus.fp_valid_o | bus.fp_ready_i;
    assign bus.bfp_ready_o = adv;

    // Stage 1: input capture
    logic                 s1_valid;
    logic [E-1:0]         s1_exp;
    logic [W*M-1:0]       s1_mant;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
        end else if (adv) begin
            s1_valid <= bus.bfp_valid_i;
            s1_exp   <= bus.bfp_exponent_i;
            s1_mant  <= bus.bfp_mantissa_i;
        end
    end

    // Leading-zero count per lane; highest set bit wins because it is visited last.
    logic [W-1:0][LW-1:0] lzc_c;

    // NOTE: every always_comb output gets a default before any condition, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        lzc_c = '0;
        for (int x = 0; x < W; x++) begin
            lzc_c[x] = LW'(M - 1);
            for (int b = 0; b < M - 1; b++) begin
                if (s1_mant[x*M + b]) lzc_c[x] = LW'(M - 2 - b);
            end
        end
    end

    // Stage 2: data plus leading-zero counts
    logic                 s2_valid;
    logic [E-1:0]         s2_exp;
    logic [W*M-1:0]       s2_mant;
    logic [W-1:0][LW-1:0] s2_lzc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_exp   <= '0;
            s2_mant  <= '0;
            s2_lzc   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_exp   <= s1_exp;
            s2_mant  <= s1_mant;
            s2_lzc   <= lzc_c;
        end
    end

    // Normalize: the underflow test comes first so the subtraction never wraps.
    logic [W*(E+M)-1:0] data_c;
    logic               uf_c;

    always_comb begin
        data_c = '0;
        uf_c   = 1'b0;
        for (int x = 0; x < W; x++) begin
            if (s2_mant[x*M +: M-1] != '0) begin
                if (s2_exp < E'(s2_lzc[x])) begin
                    uf_c = 1'b1;
                end else begin
                    data_c[x*(E+M) +: E+M] = {s2_exp - E'(s2_lzc[x]),
                                              s2_mant[x*M + M - 1],
                                              s2_mant[x*M +: M-1] << s2_lzc[x]};
                end
            end
        end
    end

    // Stage 3: output registers; data only reloads on real blocks so it keeps
    // the last result across bubbles.
    logic               s3_valid;
    logic [W*(E+M)-1:0] s3_data;
    logic               s3_uf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_data  <= '0;
            s3_uf    <= 1'b0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_data <= data_c;
                s3_uf   <= uf_c;
            end
        end
    end

    assign bus.fp_valid_o     = s3_valid;
    assign bus.fp_data_o      = s3_data;
    assign bus.fp_underflow_o = s3_uf;
endmodule

// File: tb/tb_bfp_to_fp_converter.sv
// Scoreboard bench for bfp_to_fp_converter: expected blocks are queued on input
// transfer and popped on output transfer.
module tb_bfp_to_fp_converter;
    localparam int W  = 32;
    localparam int M  = 7;
    localparam int E  = 8;
    localparam int DW = W * (E + M);

    typedef struct {
        logic [DW-1:0] data;
        logic          uf;
    } expect_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bfp_to_fp_converter_if #(
        .SYST_ARRAY_WIDTH(W), .QUNATIZED_MANTISSA_WIDTH(M), .EXPONENT_WIDTH(E)
    ) bus ();

    bfp_to_fp_converter #(
        .SYST_ARRAY_WIDTH(W), .QUNATIZED_MANTISSA_WIDTH(M), .EXPONENT_WIDTH(E)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    expect_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    // Reference: shift the magnitude up until its MSB is set, counting steps.
    function automatic expect_t model(input logic [E-1:0] ex, input logic [W*M-1:0] mt);
        expect_t r;
        logic [M-2:0] m;
        int l;
        r.data = '0;
        r.uf   = 1'b0;
        for (int x = 0; x < W; x++) begin
            m = mt[x*M +: M-1];
            l = 0;
            if (m != '0) begin
                while (!m[M-2]) begin
                    m = m << 1;
                    l++;
                end
                if (int'(ex) < l) r.uf = 1'b1;
                else r.data[x*(E+M) +: E+M] = {ex - E'(l), mt[x*M + M - 1], m};
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] lane(input int x, input logic [E-1:0] ex, input logic [M-1:0] mt);
        logic [DW-1:0] r;
        r = '0;
        r[x*(E+M) +: E+M] = {ex, mt};
        return r;
    endfunction

    task automatic monitor();
        expect_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.fp_valid_o && bus.fp_ready_i) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL sb_unexpected: got block data=%h uf=%b, required no block", bus.fp_data_o, bus.fp_underflow_o);
                end else begin
                    e = sb.pop_front();
                    if (bus.fp_data_o !== e.data || bus.fp_underflow_o !== e.uf) begin
                        mismatched++;
                        $display("FAIL sb_block: got data=%h uf=%b, required data=%h uf=%b", bus.fp_data_o, bus.fp_underflow_o, e.data, e.uf);
                    end
                end
            end
        end
    endtask

    task automatic send_block(input logic [E-1:0] ex, input logic [W*M-1:0] mt, input expect_t e);
        int waited = 0;
        @(posedge clk);
        #1;
        bus.bfp_valid_i    = 1'b1;
        bus.bfp_exponent_i = ex;
        bus.bfp_mantissa_i = mt;
        @(negedge clk);
        while (!bus.bfp_ready_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.bfp_ready_o) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: bfp_ready_o=%b after %0d cycles, required 1", bus.bfp_ready_o, waited);
        end else begin
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.bfp_valid_i = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (sb.size() != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: %0d blocks still pending, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        bus.bfp_valid_i    = 1'b0;
        bus.bfp_exponent_i = '0;
        bus.bfp_mantissa_i = '0;
        bus.fp_ready_i     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (bus.fp_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_valid: got %b, required 0", bus.fp_valid_o);
        end
        compared++;
        if (bus.fp_data_o !== '0) begin
            mismatched++;
            $display("FAIL reset_data: got %h, required 0", bus.fp_data_o);
        end
        compared++;
        if (bus.fp_underflow_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_underflow: got %b, required 0", bus.fp_underflow_o);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (bus.bfp_ready_o !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_ready: got %b, required 1", bus.bfp_ready_o);
        end
    endtask

    task automatic test_normalize();
        logic [W*M-1:0] mt;
        expect_t e;
        logic v0, v1, v2;
        mt = '0;
        mt[0 +: M] = 7'b0000100;
        e.data = lane(0, 8'h7D, 7'b0100000);
        e.uf   = 1'b0;
        send_block(8'h80, mt, e);
        @(posedge clk);
        #1;
        bus.bfp_valid_i = 1'b0;
        @(negedge clk); v0 = bus.fp_valid_o;
        @(negedge clk); v1 = bus.fp_valid_o;
        @(negedge clk); v2 = bus.fp_valid_o;
        compared++;
        if ({v0, v1, v2} !== 3'b001) begin
            mismatched++;
            $display("FAIL normalize_latency: valid after edges 1..3 = %b, required 001", {v0, v1, v2});
        end
        drain("normalize");
    endtask

    task automatic test_negative();
        logic [W*M-1:0] mt;
        expect_t e;
        mt = '0;
        mt[31*M +: M] = 7'b1100000;
        e.data = lane(31, 8'h10, 7'b1100000);
        e.uf   = 1'b0;
        send_block(8'h10, mt, e);
        idle(1);
        drain("negative");
    endtask

    task automatic test_underflow();
        logic [W*M-1:0] mt;
        expect_t e;
        mt = '0;
        mt[5*M +: M] = 7'b1000001;
        e.data = '0;
        e.uf   = 1'b1;
        send_block(8'h03, mt, e);
        e.data = lane(5, 8'h00, 7'b1100000);
        e.uf   = 1'b0;
        send_block(8'h05, mt, e);
        idle(1);
        drain("underflow");
    endtask

    task automatic test_backpressure();
        logic [E-1:0]   ex[5];
        logic [W*M-1:0] mt[5];
        logic [DW-1:0]  held;
        for (int i = 0; i < 5; i++) begin
            ex[i] = E'(8'h20 + i);
            for (int x = 0; x < W; x++) mt[i][x*M +: M] = M'($urandom);
        end
        held = '0;
        fork
            begin
                for (int i = 0; i < 5; i++) send_block(ex[i], mt[i], model(ex[i], mt[i]));
                idle(1);
            end
            begin
                for (int c = 1; c <= 10; c++) begin
                    @(posedge clk);
                    #1;
                    bus.fp_ready_i = (c < 4 || c > 7);
                    @(negedge clk);
                    if (c >= 4 && c <= 7) begin
                        if (c == 4) held = bus.fp_data_o;
                        compared++;
                        if (bus.bfp_ready_o !== 1'b0) begin
                            mismatched++;
                            $display("FAIL stall_ready c%0d: got %b, required 0", c, bus.bfp_ready_o);
                        end
                        compared++;
                        if (bus.fp_valid_o !== 1'b1 || bus.fp_data_o !== held) begin
                            mismatched++;
                            $display("FAIL stall_hold c%0d: got valid=%b data=%h, required valid=1 data=%h", c, bus.fp_valid_o, bus.fp_data_o, held);
                        end
                    end
                end
                bus.fp_ready_i = 1'b1;
            end
        join
        drain("backpressure");
    endtask

    task automatic test_reset_mid();
        logic [W*M-1:0] mt;
        expect_t e;
        bit seen;
        mt = '0;
        mt[0 +: M] = 7'b0011000;
        send_block(8'h40, mt, model(8'h40, mt));
        send_block(8'h41, mt, model(8'h41, mt));
        @(posedge clk);
        #1;
        bus.bfp_valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (bus.fp_valid_o !== 1'b0 || bus.fp_data_o !== '0) begin
            mismatched++;
            $display("FAIL midreset_clear: got valid=%b data=%h, required valid=0 data=0", bus.fp_valid_o, bus.fp_data_o);
        end
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (bus.bfp_ready_o !== 1'b1) begin
            mismatched++;
            $display("FAIL midreset_ready: got %b, required 1", bus.bfp_ready_o);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.fp_valid_o) seen = 1'b1;
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_ghost: fp_valid_o seen=%b, required 0", seen);
        end
        mt[3*M +: M] = 7'b1000010;
        e = model(8'h02, mt);
        send_block(8'h02, mt, e);
        idle(1);
        drain("midreset");
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                logic [E-1:0]   ex;
                logic [W*M-1:0] mt;
                for (int i = 0; i < 10000; i++) begin
                    ex = ($urandom_range(0, 3) == 0) ? E'($urandom_range(0, 6)) : E'($urandom);
                    for (int x = 0; x < W; x++) begin
                        if ($urandom_range(0, 3) == 0) mt[x*M +: M] = {1'($urandom_range(0, 1)), {(M-1){1'b0}}};
                        else mt[x*M +: M] = M'($urandom);
                    end
                    send_block(ex, mt, model(ex, mt));
                    if ($urandom_range(0, 7) == 0) idle(1);
                end
                idle(1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.fp_ready_i = ($urandom_range(0, 3) != 0);
                end
                bus.fp_ready_i = 1'b1;
            end
        join
        drain("random");
    endtask

    initial begin
        rst = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_normalize();
        test_negative();
        test_underflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
